// File: rtl/shift_word_serializer.sv
// Purpose : parallel-to-serial output stage; 16-bit words out one bit per clock,
//           selectable bit order per word, one-entry pending buffer for gapless streaming.
// Latency : word accepted at E0, loaded at E1 (en=1), first bit valid the cycle after E1.
// Backpr. : in_ready = rst & ~pend_full (registered, no path from in_valid); en=0 freezes the engine.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous reset, active-low (0 = reset)
//   en         shift-engine advance enable (0 = freeze shifter/count/state)
//   dir        bit order bound to the word at acceptance: 0 = LSB first, 1 = MSB first
//   data_in    word to serialize
//   in_valid   data_in/dir valid
//   in_ready   pending buffer can accept a word
//   ser_out    serial data bit
//   ser_valid  ser_out carries a bit consumed at this edge
//   sof / eof  first / last bit of a word (qualified by ser_valid)
//   busy       a word is shifting or pending
module shift_word_serializer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Shift engine
    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   shifter_q,   shifter_d;
    logic               cur_dir_q,   cur_dir_d;
    logic [CNT_W-1:0]   count_q,     count_d;

    // One-entry pending buffer
    logic [WIDTH-1:0]   pend_data_q, pend_data_d;
    logic               pend_dir_q,  pend_dir_d;
    logic               pend_full_q, pend_full_d;

    logic               shifting;
    logic               accept;
    logic               load;

    // ------------------------------------------------------------------
    // Outputs. Everything is gated by rst so the block is silent while
    // reset is held, even before the first reset edge has cleared state.
    // ------------------------------------------------------------------
    always_comb begin
        shifting  = rst & (state_q == SHIFT);
        in_ready  = rst & ~pend_full_q;
        ser_valid = shifting & en;
        // Output end of the shifter depends on the bit order of the word in flight.
        ser_out   = shifting ? (cur_dir_q ? shifter_q[WIDTH-1] : shifter_q[0]) : 1'b0;
        sof       = ser_valid & (count_q == '0);
        eof       = ser_valid & (count_q == LAST_BIT);
        busy      = rst & ((state_q == SHIFT) | pend_full_q);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        shifter_d   = shifter_q;
        cur_dir_d   = cur_dir_q;
        count_d     = count_q;
        pend_data_d = pend_data_q;
        pend_dir_d  = pend_dir_q;
        pend_full_d = pend_full_q;
        load        = 1'b0;
        accept      = in_valid & in_ready;

        case (state_q)
            IDLE: begin
                if (en && pend_full_q) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_valid) begin
                    if (count_q != LAST_BIT) begin
                        // Move the next bit to the output end; vacated bits fill with 0.
                        shifter_d = cur_dir_q ? (shifter_q << 1) : (shifter_q >> 1);
                        count_d   = count_q + CNT_W'(1);
                    end else if (pend_full_q) begin
                        // Last bit consumed with a word waiting: chain with no gap.
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            shifter_d   = pend_data_q;
            cur_dir_d   = pend_dir_q;
            count_d     = '0;
            pend_full_d = 1'b0;
        end

        // Accept needs an empty buffer and load needs a full one, so the
        // two never coincide and this write cannot clobber a load.
        if (accept) begin
            pend_data_d = data_in;
            pend_dir_d  = dir;
            pend_full_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers, synchronous active-low reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            shifter_q   <= '0;
            cur_dir_q   <= 1'b0;
            count_q     <= '0;
            pend_data_q <= '0;
            pend_dir_q  <= 1'b0;
            pend_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shifter_q   <= shifter_d;
            cur_dir_q   <= cur_dir_d;
            count_q     <= count_d;
            pend_data_q <= pend_data_d;
            pend_dir_q  <= pend_dir_d;
            pend_full_q <= pend_full_d;
        end
    end

endmodule

// File: tb/tb_shift_word_serializer.sv
// Purpose : self-checking bench for shift_word_serializer (word-level reference model
//           checked every cycle, plus literal bit-stream expectations per scenario).
// Timing  : inputs change 2 time units after the rising edge; outputs compared on the falling edge.
module tb_shift_word_serializer;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             en;
    logic             dir;
    logic [WIDTH-1:0] data_in;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             sof;
    logic             eof;
    logic             busy;

    shift_word_serializer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .dir       (dir),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .sof       (sof),
        .eof       (eof),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks whole words and a bit index into the word
    // in flight, plus at most one waiting word.
    // ------------------------------------------------------------------
    bit               m_act       = 1'b0;
    logic [WIDTH-1:0] m_data      = '0;
    bit               m_dir       = 1'b0;
    int               m_pos       = 0;
    bit               m_pend      = 1'b0;
    logic [WIDTH-1:0] m_pend_data = '0;
    bit               m_pend_dir  = 1'b0;

    logic e_rdy, e_sv, e_bit, e_sof, e_eof, e_busy, m_take;

    // Captured valid bits of the current scenario: index i = i-th valid bit.
    logic [63:0] cap_bits, cap_sof, cap_eof;
    int          cap_n, cap_first, cap_last;

    task automatic clear_cap();
        cap_bits  = '0;
        cap_sof   = '0;
        cap_eof   = '0;
        cap_n     = 0;
        cap_first = 0;
        cap_last  = 0;
    endtask

    always @(negedge clk) begin
        e_rdy  = rst && !m_pend;
        e_sv   = rst && m_act && en;
        e_bit  = (rst && m_act) ? (m_dir ? m_data[WIDTH-1-m_pos] : m_data[m_pos]) : 1'b0;
        e_sof  = e_sv && (m_pos == 0);
        e_eof  = e_sv && (m_pos == WIDTH - 1);
        e_busy = rst && (m_act || m_pend);

        chk("in_ready",  64'(in_ready),  64'(e_rdy));
        chk("ser_valid", 64'(ser_valid), 64'(e_sv));
        chk("ser_out",   64'(ser_out),   64'(e_bit));
        chk("sof",       64'(sof),       64'(e_sof));
        chk("eof",       64'(eof),       64'(e_eof));
        chk("busy",      64'(busy),      64'(e_busy));

        if (ser_valid === 1'b1 && cap_n < 64) begin
            if (cap_n == 0) cap_first = cyc;
            cap_last        = cyc;
            cap_bits[cap_n] = ser_out;
            cap_sof[cap_n]  = sof;
            cap_eof[cap_n]  = eof;
            cap_n++;
        end

        // Advance the model to the state after the coming rising edge.
        if (!rst) begin
            m_act  = 1'b0;
            m_pend = 1'b0;
            m_pos  = 0;
        end else begin
            m_take = in_valid && e_rdy;
            if (m_act && en) begin
                if (m_pos == WIDTH - 1) begin
                    if (m_pend) begin
                        m_data = m_pend_data;
                        m_dir  = m_pend_dir;
                        m_pos  = 0;
                        m_pend = 1'b0;
                    end else begin
                        m_act = 1'b0;
                    end
                end else begin
                    m_pos++;
                end
            end else if (!m_act && en && m_pend) begin
                m_act  = 1'b1;
                m_data = m_pend_data;
                m_dir  = m_pend_dir;
                m_pos  = 0;
                m_pend = 1'b0;
            end
            if (m_take) begin
                m_pend      = 1'b1;
                m_pend_data = data_in;
                m_pend_dir  = dir;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_word(input logic [WIDTH-1:0] d, input logic dr);
        logic took;
        took     = 1'b0;
        data_in  = d;
        dir      = dr;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !took; i++) begin
            took = in_ready;
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        if (!took) begin
            tests++;
            fails++;
            $display("FAIL send_timeout word %0h: in_ready never rose", d);
        end
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy !== 1'b0 && i < 200) begin
            cycles(1);
            i++;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic check_cap(input string name, input int n, input logic [63:0] bits,
                             input logic [63:0] sofm, input logic [63:0] eofm, input int span);
        chk({name, "_count"}, 64'(cap_n), 64'(n));
        chk({name, "_bits"},  cap_bits,   bits);
        chk({name, "_sof"},   cap_sof,    sofm);
        chk({name, "_eof"},   cap_eof,    eofm);
        chk({name, "_span"},  64'(cap_last - cap_first), 64'(span));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        rst      = 1'b0;
        en       = 1'b1;
        dir      = 1'b0;
        data_in  = 16'hA5C3;
        in_valid = 1'b1;
        clear_cap();

        // 1: reset held with a word offered; nothing accepted or emitted afterwards.
        cycles(2);
        chk("s1_in_ready_rst", 64'(in_ready), 64'd0);
        chk("s1_busy_rst",     64'(busy),     64'd0);
        rst      = 1'b1;
        in_valid = 1'b0;
        cycles(5);
        chk("s1_no_bits", 64'(cap_n), 64'd0);
        chk("s1_busy",    64'(busy),  64'd0);

        // 2: single word, LSB first.
        clear_cap();
        send_word(16'hA5C3, 1'b0);
        wait_idle();
        check_cap("s2", 16, 64'h0000_0000_0000_A5C3, 64'h1, 64'h8000, 15);

        // 3: 8001 MSB first then 00FF LSB first, back-to-back.
        clear_cap();
        send_word(16'h8001, 1'b1);
        send_word(16'h00FF, 1'b0);
        wait_idle();
        check_cap("s3", 32, 64'h0000_0000_00FF_8001, 64'h0000_0000_0001_0001,
                  64'h0000_0000_8000_8000, 31);

        // 4: freeze for 3 cycles after bit 5.
        clear_cap();
        send_word(16'hA5C3, 1'b0);
        cycles(6);
        en = 1'b0;
        cycles(3);
        en = 1'b1;
        wait_idle();
        check_cap("s4", 16, 64'h0000_0000_0000_A5C3, 64'h1, 64'h8000, 18);

        // 5: three words streamed; third waits for in_ready.
        clear_cap();
        send_word(16'h1234, 1'b0);
        send_word(16'hABCD, 1'b1);
        send_word(16'h5A5A, 1'b0);
        wait_idle();
        check_cap("s5", 48, 64'h0000_5A5A_B3D5_1234, 64'h0000_0001_0001_0001,
                  64'h0000_8000_8000_8000, 47);

        // 6: reset after bit 7 with a word pending, then a fresh word.
        clear_cap();
        send_word(16'hA5C3, 1'b0);
        send_word(16'h1111, 1'b0);
        for (int i = 0; i < 100 && cap_n < 7; i++) cycles(1);
        rst = 1'b0;
        cycles(1);
        rst = 1'b1;
        chk("s6_bits_before_rst", 64'(cap_n),   64'd7);
        chk("s6_no_eof",          cap_eof,      64'd0);
        chk("s6_busy",            64'(busy),    64'd0);
        chk("s6_ser_valid",       64'(ser_valid), 64'd0);
        cycles(3);
        chk("s6_quiet", 64'(cap_n), 64'd7);
        clear_cap();
        send_word(16'h0F0F, 1'b1);
        wait_idle();
        check_cap("s6", 16, 64'h0000_0000_0000_F0F0, 64'h1, 64'h8000, 15);

        cycles(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
